// File: rtl/pwm_gen_mc.sv
// pwm_gen_mc: multi-channel PWM with shared period counter and double-buffered config
// Optional dead-time insertion and complementary outputs: define PWM_DEADTIME_EN
module pwm_gen_mc #(
    parameter int CH = 4,
    parameter int W = 16
`ifdef PWM_DEADTIME_EN
    ,
    parameter int DT_W = 8
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pwm_en,
    input  logic            cfg_we,
    input  logic [3:0]      cfg_ch,
    input  logic [1:0]      cfg_sel,
    input  logic [W-1:0]    cfg_wdata,
`ifdef PWM_DEADTIME_EN
    input  logic [DT_W-1:0] dead_time,
    output logic [CH-1:0]   pwm_out_n,
`endif
    output logic [W-1:0]    cnt_out,
    output logic            period_end,
    output logic [CH-1:0]   pwm_out
);
    logic [W-1:0] cnt, period_sh, period_act;
    logic [W-1:0] cmp1_sh [CH];
    logic [W-1:0] cmp2_sh [CH];
    logic [W-1:0] cmp1_act [CH];
    logic [W-1:0] cmp2_act [CH];
    logic [2:0]   mode_sh [CH];
    logic [2:0]   mode_act [CH];
    logic         pending, pe_q, wrap, acc, xfer;
    logic [CH-1:0] r, out_q;

    assign wrap = pwm_en && cnt == period_act;
    assign acc  = cfg_we && (cfg_sel == 2'd3 || 32'(cfg_ch) < CH);
    assign xfer = pending && (wrap || !pwm_en);

    // Shared time base: free-runs to period_act then wraps, parked at 0 while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            pe_q <= 1'b0;
        end else begin
            cnt  <= (!pwm_en || wrap) ? '0 : cnt + 1'b1;
            pe_q <= wrap;
        end
    end

    // Shadow writes plus shadow-to-active transfer; a write landing on the transfer edge stays pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_sh  <= '1;
            period_act <= '1;
            pending    <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                cmp1_sh[c]  <= '0;
                cmp2_sh[c]  <= '0;
                mode_sh[c]  <= '0;
                cmp1_act[c] <= '0;
                cmp2_act[c] <= '0;
                mode_act[c] <= '0;
            end
        end else begin
            pending <= (pending && !xfer) || acc;
            if (xfer) period_act <= period_sh;
            if (cfg_we && cfg_sel == 2'd3) period_sh <= cfg_wdata;
            for (int c = 0; c < CH; c++) begin
                if (xfer) begin
                    cmp1_act[c] <= cmp1_sh[c];
                    cmp2_act[c] <= cmp2_sh[c];
                    mode_act[c] <= mode_sh[c];
                end
                if (cfg_we && cfg_ch == 4'(c)) begin
                    if (cfg_sel == 2'd0) cmp1_sh[c] <= cfg_wdata;
                    if (cfg_sel == 2'd1) cmp2_sh[c] <= cfg_wdata;
                    if (cfg_sel == 2'd2) mode_sh[c] <= cfg_wdata[2:0];
                end
            end
        end
    end

    // Raw per-channel compare result; inversion only applies while enabled
    always_comb begin
        r = '0;
        for (int c = 0; c < CH; c++)
            r[c] = pwm_en & (mode_act[c][2] ^
                (mode_act[c][1:0] == 2'd0 ? cnt < cmp1_act[c] :
                 mode_act[c][1:0] == 2'd1 ? cnt >= cmp1_act[c] :
                 mode_act[c][1:0] == 2'd2 ? (cmp1_act[c] < cmp2_act[c] &&
                                             cnt >= cmp1_act[c] && cnt < cmp2_act[c]) :
                 1'b0));
    end

`ifdef PWM_DEADTIME_EN
    logic [CH-1:0]   r_q, n_q;
    logic [DT_W-1:0] dc [CH];
    logic [DT_W-1:0] rem [CH];

    // Remaining dead band: reloaded from dead_time on every edge of r, else the running count
    always_comb begin
        for (int c = 0; c < CH; c++)
            rem[c] = (r[c] != r_q[c]) ? dead_time : dc[c];
    end

    // Each output rises only once the dead band after its r edge has elapsed, falls immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q   <= '0;
            out_q <= '0;
            n_q   <= '0;
            for (int c = 0; c < CH; c++) dc[c] <= '0;
        end else begin
            r_q <= r;
            for (int c = 0; c < CH; c++) begin
                dc[c]    <= (rem[c] == '0) ? '0 : rem[c] - 1'b1;
                out_q[c] <= r[c] && rem[c] == '0;
                n_q[c]   <= pwm_en && !r[c] && rem[c] == '0;
            end
        end
    end

    assign pwm_out_n = n_q & {CH{pwm_en}};
`else
    // Output register: one cycle behind the counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_q <= '0;
        else        out_q <= r;
    end
`endif

    assign pwm_out    = out_q & {CH{pwm_en}};
    assign period_end = pe_q & pwm_en;
    assign cnt_out    = cnt;
endmodule

// File: tb/tb_pwm_gen_mc.sv
// tb_pwm_gen_mc: directed self-checking bench for pwm_gen_mc
module tb_pwm_gen_mc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pwm_en = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_ch = '0;
    logic [1:0]  cfg_sel = '0;
    logic [15:0] cfg_wdata = '0;
    logic [15:0] cnt_out;
    logic        period_end;
    logic [3:0]  pwm_out;
    int n_chk = 0;
    int n_fail = 0;
`ifdef PWM_DEADTIME_EN
    logic [7:0]  dead_time = '0;
    logic [3:0]  pwm_out_n;
`endif

    always #5 clk = ~clk;

    pwm_gen_mc #(.CH(4), .W(16)) dut (
        .clk(clk), .rst_n(rst_n), .pwm_en(pwm_en), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
`ifdef PWM_DEADTIME_EN
        .dead_time(dead_time), .pwm_out_n(pwm_out_n),
`endif
        .cnt_out(cnt_out), .period_end(period_end), .pwm_out(pwm_out)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [1:0] sel, input logic [3:0] ch, input logic [15:0] d);
        cfg_we = 1'b1;
        cfg_sel = sel;
        cfg_ch = ch;
        cfg_wdata = d;
        tick(1);
        cfg_we = 1'b0;
    endtask

    initial begin
        int prev, c0, c1;
        tick(2);
        chk("rst_cnt", cnt_out, 0);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_pe", period_end, 0);
        rst_n = 1'b1;
        wr(3, 0, 9);
        wr(0, 0, 3);
        wr(2, 0, 0);
        wr(0, 1, 2);
        tick(1);
        pwm_en = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick(1);
            prev = (k - 1) % 10;
            c0 = (k <= 50) ? 3 : 7;
            c1 = (k <= 30) ? 2 : 5;
            chk("left_cnt", cnt_out, k % 10);
            chk("left_pe", period_end, k % 10 == 0);
            chk("left_pwm", pwm_out, {2'b0, prev < c1, prev < c0});
            if (k == 23) begin
                cfg_we = 1'b1; cfg_sel = 0; cfg_ch = 1; cfg_wdata = 5;
            end else if (k == 33) begin
                cfg_we = 1'b1; cfg_sel = 2; cfg_ch = 3; cfg_wdata = 3;
            end else if (k == 39) begin
                cfg_we = 1'b1; cfg_sel = 0; cfg_ch = 0; cfg_wdata = 7;
            end else begin
                cfg_we = 1'b0;
            end
        end
        tick(1);
        chk("pre_dis_pwm", pwm_out, 4'b0011);
        pwm_en = 1'b0;
        #1;
        chk("dis_pwm_comb", pwm_out, 0);
        chk("dis_cnt_hold", cnt_out, 1);
        tick(1);
        chk("dis_cnt_clr", cnt_out, 0);
        wr(3, 0, 15);
        wr(2, 0, 3);
        wr(2, 1, 3);
        wr(2, 2, 2);
        wr(0, 2, 4);
        wr(1, 2, 10);
        tick(1);
        pwm_en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            prev = k - 1;
            chk("win_pwm", pwm_out, {1'b0, prev >= 4 && prev < 10, 2'b0});
            chk("win_pe", period_end, k == 16);
        end
        pwm_en = 1'b0;
        wr(0, 2, 10);
        wr(1, 2, 4);
        tick(1);
        pwm_en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            chk("win_rev_pwm", pwm_out, 0);
        end
        pwm_en = 1'b0;
        wr(2, 2, 5);
        wr(0, 2, 12);
        tick(1);
        pwm_en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            prev = k - 1;
            chk("inv_right_pwm", pwm_out, {1'b0, prev < 12, 2'b0});
        end
        pwm_en = 1'b0;
        wr(2, 2, 0);
        wr(0, 2, 0);
        wr(2, 1, 0);
        wr(0, 1, 16);
        tick(1);
        pwm_en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            chk("edge_pwm", pwm_out, 4'b0010);
        end
        pwm_en = 1'b0;
        wr(3, 0, 0);
        tick(1);
        pwm_en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            chk("p0_cnt", cnt_out, 0);
            chk("p0_pe", period_end, 1);
            chk("p0_pwm", pwm_out, 4'b0010);
        end
        pwm_en = 1'b0;
        wr(3, 0, 9);
        tick(1);
        pwm_en = 1'b1;
        tick(4);
        chk("mid_cnt", cnt_out, 4);
        chk("mid_pwm", pwm_out, 4'b0010);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt", cnt_out, 0);
        chk("arst_pwm", pwm_out, 0);
        chk("arst_pe", period_end, 0);
        tick(1);
        rst_n = 1'b1;
        tick(12);
        chk("post_rst_cnt", cnt_out, 12);
        chk("post_rst_pwm", pwm_out, 0);
        chk("post_rst_pe", period_end, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
